// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------------------------
// instr_fetch: instruction fetch stage of the Q16 core.
//
// Reads one 25-bit instruction word from program ROM for each program address strobed in by the
// PC unit. Splits the word into opcode/register/data fields and holds them for the execution
// controller until it signals done. Supports debug halt and single-step through the controller's
// break line, and counts issued instructions.
//
// Ports:
//   clk_i        system clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   pc_valid_i   one-cycle strobe, new program address on pc_i
//   pc_i         program address
//   rom_addr_o   registered ROM address
//   rom_rd_o     one-cycle ROM read strobe
//   rom_data_i   instruction word, valid ROM_LAT edges after the edge that raised rom_rd_o
//   exe_o        opcode field    (word[24:20])
//   ereg1_o      register field  (word[19:18])
//   ereg2_o      register field  (word[17:16])
//   edata_o      data field      (word[15:0])
//   work_o       fields valid, held until done_i
//   done_i       current instruction consumed
//   brk_o        break to controller, high while halted
//   dbg_halt_i   level request to halt at the next instruction boundary
//   step_i       one-cycle strobe, issue one pending instruction while halted
//   icount_o     issued-instruction counter (wraps)
// ---------------------------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned ROM_LAT = 1  // legal 1..3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_valid_i,
    input  logic [14:0] pc_i,
    output logic [14:0] rom_addr_o,
    output logic        rom_rd_o,
    input  logic [24:0] rom_data_i,
    output logic [4:0]  exe_o,
    output logic [1:0]  ereg1_o,
    output logic [1:0]  ereg2_o,
    output logic [15:0] edata_o,
    output logic        work_o,
    input  logic        done_i,
    output logic        brk_o,
    input  logic        dbg_halt_i,
    input  logic        step_i,
    output logic [15:0] icount_o
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StHalt
    } state_e;

    localparam logic [1:0] CntLoad = 2'(ROM_LAT - 1);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [14:0] rom_addr_q;
    logic        rom_rd_q;
    logic [4:0]  exe_q;
    logic [1:0]  ereg1_q;
    logic [1:0]  ereg2_q;
    logic [15:0] edata_q;
    logic        work_q;
    logic        brk_q;
    logic [15:0] icount_q;
    logic        pend_q;
    logic [14:0] pend_addr_q;

    // While halted, an address strobed in this very cycle counts as pending and supersedes
    // any older pending address.
    logic        halt_pend;
    logic [14:0] halt_pc;

    assign halt_pend = pc_valid_i | pend_q;
    assign halt_pc   = pc_valid_i ? pc_i : pend_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            rom_addr_q  <= 15'd0;
            rom_rd_q    <= 1'b0;
            exe_q       <= 5'd0;
            ereg1_q     <= 2'd0;
            ereg2_q     <= 2'd0;
            edata_q     <= 16'd0;
            work_q      <= 1'b0;
            brk_q       <= 1'b0;
            icount_q    <= 16'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= 15'd0;
        end else begin
            rom_rd_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pc_valid_i) begin
                        rom_addr_q <= pc_i;
                        rom_rd_q   <= 1'b1;
                        cnt_q      <= CntLoad;
                        state_q    <= StFetch;
                    end
                end
                StFetch: begin
                    if (pc_valid_i) begin
                        // Flush: abandon the outstanding read and restart on the new address.
                        rom_addr_q <= pc_i;
                        rom_rd_q   <= 1'b1;
                        cnt_q      <= CntLoad;
                    end else if (!rom_rd_q) begin
                        // The cycle with rom_rd high is the ROM address cycle; latency
                        // counting starts after it.
                        if (cnt_q == 2'd0) begin
                            exe_q    <= rom_data_i[24:20];
                            ereg1_q  <= rom_data_i[19:18];
                            ereg2_q  <= rom_data_i[17:16];
                            edata_q  <= rom_data_i[15:0];
                            work_q   <= 1'b1;
                            icount_q <= icount_q + 16'd1;
                            state_q  <= StIssue;
                        end else begin
                            cnt_q <= cnt_q - 2'd1;
                        end
                    end
                end
                StIssue: begin
                    if (done_i) begin
                        work_q <= 1'b0;
                        if (dbg_halt_i) begin
                            brk_q   <= 1'b1;
                            state_q <= StHalt;
                        end else if (pc_valid_i) begin
                            rom_addr_q <= pc_i;
                            rom_rd_q   <= 1'b1;
                            cnt_q      <= CntLoad;
                            state_q    <= StFetch;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StHalt: begin
                    if (!dbg_halt_i || (step_i && halt_pend)) begin
                        brk_q  <= 1'b0;
                        pend_q <= 1'b0;
                        if (halt_pend) begin
                            rom_addr_q <= halt_pc;
                            rom_rd_q   <= 1'b1;
                            cnt_q      <= CntLoad;
                            state_q    <= StFetch;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (pc_valid_i) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= pc_i;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign rom_rd_o   = rom_rd_q;
    assign exe_o      = exe_q;
    assign ereg1_o    = ereg1_q;
    assign ereg2_o    = ereg2_q;
    assign edata_o    = edata_q;
    assign work_o     = work_q;
    assign brk_o      = brk_q;
    assign icount_o   = icount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------------------------
// tb_instr_fetch: self-checking bench for instr_fetch.
//
// Two instances run side by side from the same stimulus, one with ROM_LAT=1 and one with
// ROM_LAT=3, each fed by its own ROM model that drives a word only during the single cycle it is
// valid. A selector picks which instance is being checked. Expectations come from the ROM
// contents function, the configured latency and a transaction-level issue counter.
// ---------------------------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [24:0] RomIdle = 25'h15A5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_valid;
    logic [14:0] pc;
    logic        done;
    logic        dbg_halt;
    logic        step;

    logic [14:0] a_rom_addr, b_rom_addr;
    logic        a_rom_rd, b_rom_rd;
    logic [24:0] a_rom_data, b_rom_data;
    logic [4:0]  a_exe, b_exe;
    logic [1:0]  a_ereg1, b_ereg1, a_ereg2, b_ereg2;
    logic [15:0] a_edata, b_edata, a_icount, b_icount;
    logic        a_work, b_work, a_brk, b_brk;

    int checks = 0;
    int fails  = 0;

    logic        sel;
    int unsigned lat;
    logic [15:0] exp_icnt;
    logic [24:0] last_w;

    always #5 clk = ~clk;

    instr_fetch #(.ROM_LAT(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .pc_valid_i(pc_valid), .pc_i(pc),
        .rom_addr_o(a_rom_addr), .rom_rd_o(a_rom_rd), .rom_data_i(a_rom_data),
        .exe_o(a_exe), .ereg1_o(a_ereg1), .ereg2_o(a_ereg2), .edata_o(a_edata),
        .work_o(a_work), .done_i(done), .brk_o(a_brk), .dbg_halt_i(dbg_halt),
        .step_i(step), .icount_o(a_icount)
    );

    instr_fetch #(.ROM_LAT(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .pc_valid_i(pc_valid), .pc_i(pc),
        .rom_addr_o(b_rom_addr), .rom_rd_o(b_rom_rd), .rom_data_i(b_rom_data),
        .exe_o(b_exe), .ereg1_o(b_ereg1), .ereg2_o(b_ereg2), .edata_o(b_edata),
        .work_o(b_work), .done_i(done), .brk_o(b_brk), .dbg_halt_i(dbg_halt),
        .step_i(step), .icount_o(b_icount)
    );

    // Program ROM contents; address 5 holds the fixed basic-fetch pattern.
    function automatic logic [24:0] rom_word(input logic [14:0] a);
        if (a == 15'h0005) return {5'd11, 2'd2, 2'd1, 16'h1234};
        return {a[4:0] ^ a[14:10], a[6:5], a[8:7], {1'b1, a} ^ 16'h3C5A};
    endfunction

    // ROM models: word appears ROM_LAT edges after the edge that raised rom_rd, for one cycle.
    logic        va = 1'b0;
    logic [14:0] pa = '0;
    always @(posedge clk) begin
        va <= a_rom_rd;
        pa <= a_rom_addr;
    end
    assign a_rom_data = va ? rom_word(pa) : RomIdle;

    logic [2:0]  vb = '0;
    logic [14:0] pb0 = '0, pb1 = '0, pb2 = '0;
    always @(posedge clk) begin
        vb  <= {vb[1:0], b_rom_rd};
        pb0 <= b_rom_addr;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign b_rom_data = vb[2] ? rom_word(pb2) : RomIdle;

    logic [14:0] c_rom_addr;
    logic        c_rom_rd, c_work, c_brk;
    logic [4:0]  c_exe;
    logic [1:0]  c_ereg1, c_ereg2;
    logic [15:0] c_edata, c_icount;
    assign c_rom_addr = sel ? b_rom_addr : a_rom_addr;
    assign c_rom_rd   = sel ? b_rom_rd   : a_rom_rd;
    assign c_work     = sel ? b_work     : a_work;
    assign c_brk      = sel ? b_brk      : a_brk;
    assign c_exe      = sel ? b_exe      : a_exe;
    assign c_ereg1    = sel ? b_ereg1    : a_ereg1;
    assign c_ereg2    = sel ? b_ereg2    : a_ereg2;
    assign c_edata    = sel ? b_edata    : a_edata;
    assign c_icount   = sel ? b_icount   : a_icount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s (lat=%0d): got %0h, want %0h", tag, lat, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rom_addr"}, 32'(c_rom_addr), 32'd0);
        chk({tag, " rom_rd"},   32'(c_rom_rd),   32'd0);
        chk({tag, " exe"},      32'(c_exe),      32'd0);
        chk({tag, " ereg1"},    32'(c_ereg1),    32'd0);
        chk({tag, " ereg2"},    32'(c_ereg2),    32'd0);
        chk({tag, " edata"},    32'(c_edata),    32'd0);
        chk({tag, " work"},     32'(c_work),     32'd0);
        chk({tag, " brk"},      32'(c_brk),      32'd0);
        chk({tag, " icount"},   32'(c_icount),   32'd0);
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        pc_valid = 1'b0;
        pc       = '0;
        done     = 1'b0;
        dbg_halt = 1'b0;
        step     = 1'b0;
        tick;
        tick;
        rst_n    = 1'b1;
        tick;
        exp_icnt = '0;
    endtask

    // Called just after the edge that launched a read; waits (bounded) for work and checks
    // latency, fields and counter.
    task automatic issue_wait(input logic [14:0] addr, input string tag);
        int n = 0;
        logic [24:0] w;
        w = rom_word(addr);
        while (!c_work && n < 12) begin
            tick;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat + 1));
        chk({tag, " exe"},   32'(c_exe),   32'(w[24:20]));
        chk({tag, " ereg1"}, 32'(c_ereg1), 32'(w[19:18]));
        chk({tag, " ereg2"}, 32'(c_ereg2), 32'(w[17:16]));
        chk({tag, " edata"}, 32'(c_edata), 32'(w[15:0]));
        exp_icnt = exp_icnt + 16'd1;
        chk({tag, " icount"}, 32'(c_icount), 32'(exp_icnt));
        chk({tag, " brk"},    32'(c_brk),    32'd0);
        last_w = w;
    endtask

    task automatic start(input logic [14:0] addr, input string tag);
        pc       = addr;
        pc_valid = 1'b1;
        tick;
        pc_valid = 1'b0;
        chk({tag, " rom_rd"},   32'(c_rom_rd),   32'd1);
        chk({tag, " rom_addr"}, 32'(c_rom_addr), 32'(addr));
        issue_wait(addr, tag);
    endtask

    task automatic hold(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            tick;
            chk({tag, " hold work"}, 32'(c_work), 32'd1);
            chk({tag, " hold fields"}, {7'd0, c_exe, c_ereg1, c_ereg2, c_edata}, {7'd0, last_w});
        end
    endtask

    task automatic finish(input logic nxt, input logic [14:0] addr, input string tag);
        done     = 1'b1;
        pc_valid = nxt;
        pc       = addr;
        tick;
        done     = 1'b0;
        pc_valid = 1'b0;
        chk({tag, " done work"}, 32'(c_work), 32'd0);
        chk({tag, " kept fields"}, {7'd0, c_exe, c_ereg1, c_ereg2, c_edata}, {7'd0, last_w});
        if (nxt) begin
            chk({tag, " b2b rom_rd"}, 32'(c_rom_rd), 32'd1);
            issue_wait(addr, {tag, " b2b"});
        end
    endtask

    task automatic do_flush(input logic [14:0] a1, input logic [14:0] a2, input string tag);
        pc       = a1;
        pc_valid = 1'b1;
        tick;
        chk({tag, " rd1"}, 32'(c_rom_rd), 32'd1);
        pc = a2;
        tick;
        pc_valid = 1'b0;
        chk({tag, " rd2"},   32'(c_rom_rd),   32'd1);
        chk({tag, " addr2"}, 32'(c_rom_addr), 32'(a2));
        issue_wait(a2, tag);
    endtask

    task automatic random_run(input int n);
        logic [14:0] a;
        logic [14:0] a2;
        logic        nxt;
        a = 15'($urandom);
        start(a, "rnd start");
        for (int i = 0; i < n; i++) begin
            hold(int'($urandom_range(0, 3)), "rnd");
            nxt = 1'($urandom_range(0, 1));
            a   = 15'($urandom);
            finish(nxt, a, "rnd");
            if (!nxt) begin
                repeat ($urandom_range(0, 2)) tick;
                if ($urandom_range(0, 3) == 0) begin
                    a2 = 15'($urandom);
                    do_flush(a, a2, "rnd flush");
                end else begin
                    start(a, "rnd");
                end
            end
        end
        finish(1'b0, '0, "rnd end");
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 1'b0;
        lat = 1;
        last_w = '0;
        do_reset;
        chk_zero("reset");

        // Asynchronous reset in the middle of a fetch.
        pc       = 15'h0030;
        pc_valid = 1'b1;
        tick;
        pc_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        rst_n    = 1'b1;
        exp_icnt = '0;
        start(15'h0010, "post reset");
        finish(1'b0, '0, "post reset");

        // Basic fetch with the fixed pattern.
        do_reset;
        start(15'h0005, "basic");
        hold(5, "basic");
        finish(1'b0, '0, "basic");
        chk("basic icount", 32'(c_icount), 32'd1);

        do_flush(15'h0100, 15'h0200, "flush");
        finish(1'b0, '0, "flush");

        // Debug halt, pending address, step, resume.
        start(15'h0021, "dbg pre");
        dbg_halt = 1'b1;
        tick;
        chk("dbg hold work", 32'(c_work), 32'd1);
        finish(1'b0, '0, "dbg pre");
        chk("halt brk", 32'(c_brk), 32'd1);
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("step nopend brk", 32'(c_brk), 32'd1);
        chk("step nopend rd",  32'(c_rom_rd), 32'd0);
        pc       = 15'h0007;
        pc_valid = 1'b1;
        tick;
        pc_valid = 1'b0;
        repeat (4) tick;
        chk("halt no issue work", 32'(c_work), 32'd0);
        chk("halt no issue rd",   32'(c_rom_rd), 32'd0);
        chk("halt icount",        32'(c_icount), 32'(exp_icnt));
        chk("halt brk held",      32'(c_brk), 32'd1);
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("step brk",  32'(c_brk), 32'd0);
        chk("step rd",   32'(c_rom_rd), 32'd1);
        chk("step addr", 32'(c_rom_addr), 32'h0007);
        issue_wait(15'h0007, "step");
        hold(2, "step");
        finish(1'b0, '0, "step");
        chk("step rehalt brk", 32'(c_brk), 32'd1);
        pc       = 15'h0044;
        pc_valid = 1'b1;
        tick;
        pc_valid = 1'b0;
        dbg_halt = 1'b0;
        tick;
        chk("resume brk",  32'(c_brk), 32'd0);
        chk("resume rd",   32'(c_rom_rd), 32'd1);
        chk("resume addr", 32'(c_rom_addr), 32'h0044);
        issue_wait(15'h0044, "resume");
        finish(1'b0, '0, "resume");

        // Halt requested from IDLE only bites at the done boundary.
        dbg_halt = 1'b1;
        start(15'h0060, "dbg idle");
        finish(1'b0, '0, "dbg idle");
        chk("dbg idle brk", 32'(c_brk), 32'd1);
        dbg_halt = 1'b0;
        tick;
        chk("release brk", 32'(c_brk), 32'd0);
        chk("release rd",  32'(c_rom_rd), 32'd0);
        start(15'h0051, "after release");
        finish(1'b0, '0, "after release");

        // Counter wrap from a preloaded value.
        force u_a.icount_q = 16'hFFFE;
        tick;
        release u_a.icount_q;
        exp_icnt = 16'hFFFE;
        tick;
        chk("preload icount", 32'(c_icount), 32'h0000FFFE);
        start(15'h0123, "wrap1");
        finish(1'b1, 15'h0124, "wrap2");
        chk("wrap icount", 32'(c_icount), 32'd0);
        finish(1'b0, '0, "wrap end");

        random_run(20);

        // ROM_LAT = 3 instance.
        sel = 1'b1;
        lat = 3;
        do_reset;
        chk_zero("reset3");
        start(15'h0005, "b2b3 0");
        finish(1'b1, 15'h0301, "b2b3 1");
        finish(1'b1, 15'h0302, "b2b3 2");
        finish(1'b1, 15'h0303, "b2b3 3");
        chk("b2b3 icount", 32'(c_icount), 32'd4);
        finish(1'b0, '0, "b2b3 end");
        do_flush(15'h0100, 15'h0200, "flush3");
        finish(1'b0, '0, "flush3");
        random_run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
